// File: rtl/eval_seq_pkg.sv
// eval_seq_pkg: shared state, job and result types for eval_sequencer
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif
package eval_seq_pkg;
  localparam int BOARD_W = `BOARD_WIDTH;
  localparam int EVAL_W = 24;
  localparam int TAG_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_EVAL, S_CLEAR, S_OUT} state_e;
  typedef struct packed {
    logic [BOARD_W-1:0] board;
    logic white_to_move;
    logic [3:0] castle_mask;
    logic [TAG_W-1:0] tag;
  } job_t;
  typedef struct packed {
    logic signed [EVAL_W-1:0] eval;
    logic insufficient;
    logic timeout;
    logic [TAG_W-1:0] tag;
  } result_t;
endpackage

// File: rtl/eval_seq_fifo.sv
// eval_seq_fifo: synchronous job queue with full/empty flags and no write bypass
module eval_seq_fifo
  import eval_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/eval_sequencer.sv
// eval_sequencer: queued attack-then-evaluate sequencer with handshaked results.
// EVAL_SEQ_TIMEOUT_EN adds a per-phase watchdog that forces a timed-out result.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif
module eval_sequencer
  import eval_seq_pkg::*;
#(
  parameter int EVAL_WIDTH = 24,
  parameter int BOARD_WIDTH = `BOARD_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BOARD_WIDTH-1:0] in_board,
  input  logic                   in_white_to_move,
  input  logic [3:0]             in_castle_mask,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic [BOARD_WIDTH-1:0] job_board,
  output logic                   job_white_to_move,
  output logic [3:0]             job_castle_mask,
  output logic                   attack_board_valid,
  output logic                   clear_attack,
  input  logic                   is_attacking_done,
  output logic                   eval_board_valid,
  input  logic                   eval_valid,
  input  logic [EVAL_WIDTH-1:0]  eval,
  input  logic                   insufficient_material,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EVAL_WIDTH-1:0]  out_eval,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_insufficient,
  output logic                   out_timeout,
  output logic                   busy,
  output logic [31:0]            jobs_done
);
  localparam int JW = BOARD_WIDTH + 5 + TAG_WIDTH;
  state_e state, nxt;
  logic full, empty, pop, eval_ok, to, cap;
  logic [JW-1:0] head;
  logic [TAG_WIDTH-1:0] job_tag;
  assign in_ready = !full;
  assign pop = state == S_IDLE && !empty;
  assign busy = state != S_IDLE || !empty;
  assign attack_board_valid = state == S_ATTACK || state == S_EVAL;
  assign clear_attack = state == S_CLEAR;
  assign out_valid = state == S_OUT;
  // a score arriving alongside the eval_board_valid pulse belongs to no request yet
  assign eval_ok = state == S_EVAL && eval_valid && !eval_board_valid;
  assign cap = eval_ok || (to && nxt == S_CLEAR);
  eval_seq_fifo #(.W(JW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset_n,
    .push(in_valid && in_ready),
    .din({in_board, in_white_to_move, in_castle_mask, in_tag}),
    .pop, .dout(head), .full, .empty
  );
`ifdef EVAL_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd;
  assign to = attack_board_valid && wd == WD_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wd <= '0;
      out_timeout <= 1'b0;
    end else begin
      wd <= nxt != state ? '0 : wd + 1'b1;
      if (cap) out_timeout <= !eval_ok;
    end
`else
  assign to = 1'b0;
  assign out_timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = empty ? S_IDLE : S_ATTACK;
      S_ATTACK: nxt = is_attacking_done ? S_EVAL : to ? S_CLEAR : S_ATTACK;
      S_EVAL:   nxt = eval_ok || to ? S_CLEAR : S_EVAL;
      S_CLEAR:  nxt = S_OUT;
      S_OUT:    nxt = out_ready ? S_IDLE : S_OUT;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      job_board <= '0;
      job_white_to_move <= 1'b0;
      job_castle_mask <= '0;
      job_tag <= '0;
      eval_board_valid <= 1'b0;
      out_eval <= '0;
      out_tag <= '0;
      out_insufficient <= 1'b0;
      jobs_done <= '0;
    end else begin
      eval_board_valid <= state == S_ATTACK && is_attacking_done;
      if (pop) {job_board, job_white_to_move, job_castle_mask, job_tag} <= head;
      if (cap) begin
        out_eval <= eval_ok ? eval : '0;
        out_insufficient <= eval_ok && insufficient_material;
        out_tag <= job_tag;
      end
      if (state == S_OUT && out_ready) jobs_done <= jobs_done + 32'd1;
    end
endmodule

// File: tb/tb_eval_sequencer.sv
// tb_eval_sequencer: directed checks of queueing, handshakes, stalls, watchdog and reset
module tb_eval_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid, in_ready, in_white_to_move, attack_board_valid, clear_attack;
  logic is_attacking_done, eval_board_valid, eval_valid, insufficient_material;
  logic out_valid, out_ready, out_insufficient, out_timeout, busy;
  logic job_white_to_move;
  logic [63:0] in_board, job_board;
  logic [3:0] in_castle_mask, job_castle_mask;
  logic [7:0] in_tag, out_tag;
  logic signed [23:0] eval, out_eval;
  logic [31:0] jobs_done;
  int n_chk = 0, n_pass = 0, n_ebv = 0, n_clr = 0, n_ov = 0;

  eval_sequencer #(.BOARD_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_board(in_board), .in_white_to_move(in_white_to_move),
    .in_castle_mask(in_castle_mask), .in_tag(in_tag), .job_board(job_board),
    .job_white_to_move(job_white_to_move), .job_castle_mask(job_castle_mask),
    .attack_board_valid(attack_board_valid), .clear_attack(clear_attack),
    .is_attacking_done(is_attacking_done), .eval_board_valid(eval_board_valid),
    .eval_valid(eval_valid), .eval(eval), .insufficient_material(insufficient_material),
    .out_valid(out_valid), .out_ready(out_ready), .out_eval(out_eval), .out_tag(out_tag),
    .out_insufficient(out_insufficient), .out_timeout(out_timeout), .busy(busy),
    .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (eval_board_valid) n_ebv++;
    if (clear_attack) n_clr++;
    if (out_valid) n_ov++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] tag, input logic [63:0] b);
    int k = 0;
    in_valid = 1'b1;
    in_tag = tag;
    in_board = b;
    in_white_to_move = tag[0];
    in_castle_mask = tag[3:0];
    while (!in_ready && k < 50) begin
      cyc(1);
      k++;
    end
    chk("push_ready", in_ready, 1);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic serve(input logic signed [23:0] ev, output logic [7:0] tag,
                       output logic signed [23:0] got);
    int k = 0;
    while (!attack_board_valid && k < 50) begin
      cyc(1);
      k++;
    end
    is_attacking_done = 1'b1;
    cyc(1);
    is_attacking_done = 1'b0;
    cyc(1);
    eval = ev;
    eval_valid = 1'b1;
    cyc(1);
    eval_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      cyc(1);
      k++;
    end
    chk("serve_out_valid", out_valid, 1);
    tag = out_tag;
    got = out_eval;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    int e0, c0, o0, acc, bad, k;
    logic [7:0] t;
    logic signed [23:0] v;
    in_valid = 0; in_board = 0; in_white_to_move = 0; in_castle_mask = 0; in_tag = 0;
    is_attacking_done = 0; eval_valid = 0; eval = 0; insufficient_material = 0; out_ready = 0;
    cyc(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_attack", attack_board_valid, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_job_board", job_board, 0);
    reset_n = 1'b1;
    cyc(1);
    // single job, tag 0x11
    push(8'h11, 64'hDEAD_BEEF_0123_4567);
    chk("t1_busy_queued", busy, 1);
    chk("t1_idle_attack", attack_board_valid, 0);
    cyc(1);
    chk("t1_attack_rise", attack_board_valid, 1);
    chk("t1_job_board", job_board, 64'hDEAD_BEEF_0123_4567);
    chk("t1_job_castle", job_castle_mask, 4'h1);
    chk("t1_job_wtm", job_white_to_move, 1);
    e0 = n_ebv;
    c0 = n_clr;
    cyc(4);
    is_attacking_done = 1'b1;
    cyc(1);
    is_attacking_done = 1'b0;
    chk("t1_ebv_pulse", eval_board_valid, 1);
    cyc(1);
    chk("t1_ebv_drop", eval_board_valid, 0);
    chk("t1_attack_held", attack_board_valid, 1);
    cyc(1);
    eval = -150;
    eval_valid = 1'b1;
    cyc(1);
    eval_valid = 1'b0;
    chk("t1_clear", clear_attack, 1);
    chk("t1_attack_off", attack_board_valid, 0);
    cyc(1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_tag", out_tag, 8'h11);
    chk("t1_out_eval", out_eval, -150);
    chk("t1_out_timeout", out_timeout, 0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("t1_out_drop", out_valid, 0);
    chk("t1_jobs_done", jobs_done, 1);
    chk("t1_busy_idle", busy, 0);
    chk("t1_ebv_count", n_ebv - e0, 1);
    chk("t1_clr_count", n_clr - c0, 1);
    // spurious handshakes, then a 20-cycle result stall
    push(8'h22, 64'h22);
    cyc(1);
    eval = 999;
    eval_valid = 1'b1;
    cyc(1);
    eval_valid = 1'b0;
    chk("sp_still_attack", attack_board_valid, 1);
    chk("sp_no_clear", clear_attack, 0);
    is_attacking_done = 1'b1;
    cyc(1);
    is_attacking_done = 1'b0;
    cyc(1);
    is_attacking_done = 1'b1;
    cyc(1);
    is_attacking_done = 1'b0;
    chk("sp_eval_held", attack_board_valid, 1);
    chk("sp_no_ebv", eval_board_valid, 0);
    chk("sp_no_clear2", clear_attack, 0);
    eval = 77;
    insufficient_material = 1'b1;
    eval_valid = 1'b1;
    cyc(1);
    eval_valid = 1'b0;
    insufficient_material = 1'b0;
    cyc(1);
    chk("sp_out_eval", out_eval, 77);
    chk("sp_out_insuf", out_insufficient, 1);
    chk("sp_out_tag", out_tag, 8'h22);
    push(8'h33, 64'h33);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_eval !== 24'sd77 || attack_board_valid !== 1'b0) bad++;
      cyc(1);
    end
    chk("stall_stable", bad, 0);
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("stall_jobs_done", jobs_done, 2);
    serve(-5, t, v);
    chk("stall_next_tag", t, 8'h33);
    chk("stall_next_eval", v, -5);
    // back-pressure: six offers, four queued plus one in flight
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_tag = 8'(i);
      in_board = 64'(i);
      if (in_ready) acc++;
      cyc(1);
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready_low", in_ready, 0);
    serve(100, t, v);
    chk("bp_tag1", t, 1);
    chk("bp_eval1", v, 100);
    chk("bp_no_bypass", in_ready, 0);
    push(8'd6, 64'd6);
    for (int i = 2; i <= 6; i++) begin
      serve(24'(i * 10), t, v);
      chk("bp_order", t, 8'(i));
    end
    chk("bp_jobs_done", jobs_done, 9);
`ifdef EVAL_SEQ_TIMEOUT_EN
    e0 = n_ebv;
    push(8'hAA, 64'hAA);
    k = 0;
    while (!out_valid && k < 60) begin
      cyc(1);
      k++;
    end
    chk("wd_out_valid", out_valid, 1);
    chk("wd_timeout", out_timeout, 1);
    chk("wd_eval", out_eval, 0);
    chk("wd_tag", out_tag, 8'hAA);
    chk("wd_no_ebv", n_ebv - e0, 0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
`endif
    // reset in EVAL with two jobs queued
    o0 = n_ov;
    push(8'h41, 64'h41);
    push(8'h42, 64'h42);
    push(8'h43, 64'h43);
    is_attacking_done = 1'b1;
    cyc(1);
    is_attacking_done = 1'b0;
    chk("rs_in_eval", eval_board_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rs_attack", attack_board_valid, 0);
    chk("rs_ebv", eval_board_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_jobs_done", jobs_done, 0);
    chk("rs_out_tag", out_tag, 0);
    chk("rs_job_board", job_board, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(5);
    chk("rs_busy_after", busy, 0);
    chk("rs_no_result", n_ov - o0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
